// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
// Module  : lsu
// Brief   : Load/store unit; one request at a time, size-encoded memory
//           accesses, optional byte splitting of misaligned half/word accesses.
// Rev     : 1.0
// ============================================================================
module lsu #(
    parameter int unsigned RD_LAT           = 1,
    parameter bit          SPLIT_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_addr,
    output logic [1:0]  mem_sel,
    output logic        mem_wen,
    output logic [31:0] mem_data_i,
    input  logic [31:0] mem_data_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam bit         NO_LAT   = (RD_LAT == 0);
    localparam logic [1:0] LAT_INIT = 2'((RD_LAT > 0) ? (RD_LAT - 1) : 0);

    state_t      state_q;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        split_q;
    logic [1:0]  last_q;
    logic [1:0]  byte_q;
    logic [1:0]  lat_q;
    logic [31:0] acc_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;
    logic [31:0] mem_addr_q;
    logic [1:0]  mem_sel_q;
    logic        mem_wen_q;
    logic [31:0] mem_data_q;

    // Request decode, evaluated on the accept cycle
    logic [1:0]  req_sel_d;
    logic        req_legal_d;
    logic        req_misal_d;
    logic        req_split_d;
    logic        req_err_d;
    logic [1:0]  req_last_d;
    logic [31:0] req_data_d;

    always_comb begin
        req_sel_d   = req_funct3[1:0];
        if (req_we) begin
            req_legal_d = !req_funct3[2] && (req_funct3[1:0] != 2'b11);
        end else begin
            req_legal_d = (req_funct3 != 3'b011) && (req_funct3 != 3'b110) &&
                          (req_funct3 != 3'b111);
        end
        req_misal_d = ((req_sel_d == 2'd1) && req_addr[0]) ||
                      ((req_sel_d == 2'd2) && (req_addr[1:0] != 2'b00));
        req_split_d = req_misal_d && SPLIT_MISALIGNED;
        req_err_d   = !req_legal_d || (req_misal_d && !SPLIT_MISALIGNED);
        req_last_d  = 2'd0;
        if (req_split_d) begin
            req_last_d = (req_sel_d == 2'd2) ? 2'd3 : 2'd1;
        end
        if (req_split_d || (req_sel_d == 2'd0)) begin
            req_data_d = {24'd0, req_wdata[7:0]};
        end else if (req_sel_d == 2'd1) begin
            req_data_d = {16'd0, req_wdata[15:0]};
        end else begin
            req_data_d = req_wdata;
        end
    end

    // Per-byte stepping and load data assembly
    logic [1:0]  byte_nxt_d;
    logic [31:0] addr_nxt_d;
    logic [31:0] wbyte_nxt_d;
    logic [31:0] acc_d;
    logic [31:0] load_d;
    logic [31:0] ext_d;
    logic        step_d;

    always_comb begin
        byte_nxt_d  = byte_q + 2'd1;
        addr_nxt_d  = addr_q + {30'd0, byte_nxt_d};
        wbyte_nxt_d = {24'd0, 8'(wdata_q >> {byte_nxt_d, 3'b000})};
        acc_d       = acc_q | ({24'd0, mem_data_o[7:0]} << {byte_q, 3'b000});
        load_d      = split_q ? acc_d : mem_data_o;
        case (funct3_q)
            3'b000:  ext_d = {{24{load_d[7]}}, load_d[7:0]};
            3'b001:  ext_d = {{16{load_d[15]}}, load_d[15:0]};
            3'b100:  ext_d = {24'd0, load_d[7:0]};
            3'b101:  ext_d = {16'd0, load_d[15:0]};
            default: ext_d = load_d;
        endcase
        // A step either completes a store byte or samples the current load byte
        step_d = ((state_q == ACCESS) && (we_q || NO_LAT)) ||
                 ((state_q == WAIT) && (lat_q == 2'd0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            funct3_q    <= 3'd0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            split_q     <= 1'b0;
            last_q      <= 2'd0;
            byte_q      <= 2'd0;
            lat_q       <= 2'd0;
            acc_q       <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_sel_q   <= 2'd0;
            mem_wen_q   <= 1'b0;
            mem_data_q  <= 32'd0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
            mem_wen_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q     <= req_we;
                        funct3_q <= req_funct3;
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        split_q  <= req_split_d;
                        last_q   <= req_last_d;
                        byte_q   <= 2'd0;
                        acc_q    <= 32'd0;
                        if (req_err_d) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                        end else begin
                            state_q    <= ACCESS;
                            mem_addr_q <= req_addr;
                            mem_sel_q  <= req_split_d ? 2'd0 : req_sel_d;
                            mem_wen_q  <= req_we;
                            mem_data_q <= req_data_d;
                        end
                    end
                end
                ACCESS, WAIT: begin
                    if (step_d) begin
                        if (!we_q) begin
                            acc_q <= acc_d;
                        end
                        if (byte_q == last_q) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= we_q ? 32'd0 : ext_d;
                        end else begin
                            state_q    <= ACCESS;
                            byte_q     <= byte_nxt_d;
                            mem_addr_q <= addr_nxt_d;
                            mem_wen_q  <= we_q;
                            mem_data_q <= wbyte_nxt_d;
                        end
                    end else if (state_q == ACCESS) begin
                        state_q <= WAIT;
                        lat_q   <= LAT_INIT;
                    end else begin
                        lat_q <= lat_q - 2'd1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign rsp_err    = rsp_err_q;
    assign mem_addr   = mem_addr_q;
    assign mem_sel    = mem_sel_q;
    assign mem_wen    = mem_wen_q;
    assign mem_data_i = mem_data_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu.sv
`default_nettype none
// ============================================================================
// Module  : tb_lsu
// Brief   : Self-checking bench for lsu: split/latency-1 and unsplit/latency-2
//           instances against a request-level behavioural model.
// Rev     : 1.0
// ============================================================================
module tb_lsu;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        vld [2];
    logic        rdy [2];
    logic        rv  [2];
    logic [31:0] rd  [2];
    logic        re  [2];
    logic [31:0] ma  [2];
    logic [1:0]  ms  [2];
    logic        mw  [2];
    logic [31:0] md  [2];
    logic [31:0] mo  [2];

    int LAT   [2] = '{1, 2};
    bit SPLIT [2] = '{1'b1, 1'b0};

    lsu #(.RD_LAT(1), .SPLIT_MISALIGNED(1'b1)) u_a (
        .clk(clk), .rst_n(rst_n), .req_valid(vld[0]), .req_ready(rdy[0]),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv[0]), .rsp_rdata(rd[0]), .rsp_err(re[0]),
        .mem_addr(ma[0]), .mem_sel(ms[0]), .mem_wen(mw[0]), .mem_data_i(md[0]), .mem_data_o(mo[0])
    );

    lsu #(.RD_LAT(2), .SPLIT_MISALIGNED(1'b0)) u_b (
        .clk(clk), .rst_n(rst_n), .req_valid(vld[1]), .req_ready(rdy[1]),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv[1]), .rsp_rdata(rd[1]), .rsp_err(re[1]),
        .mem_addr(ma[1]), .mem_sel(ms[1]), .mem_wen(mw[1]), .mem_data_i(md[1]), .mem_data_o(mo[1])
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Environment memory (written by the DUTs) and the model's reference memory
    logic [7:0] bmem [256];
    logic [7:0] rmem [256];
    logic       clr;
    logic [31:0] pa, pb0, pb1;

    function automatic int nbytes(input logic [1:0] sel);
        return (sel == 2'd0) ? 1 : (sel == 2'd1) ? 2 : 4;
    endfunction

    // Bits above the access size carry junk so unmasked use shows up
    function automatic logic [31:0] mem_read(input logic [31:0] a, input logic [1:0] sel);
        logic [31:0] v;
        v = 32'hDEADBEEF;
        for (int k = 0; k < 4; k++)
            if (k < nbytes(sel)) v[8*k +: 8] = bmem[8'(a + 32'(k))];
        return v;
    endfunction

    always @(posedge clk) begin
        pa  <= mem_read(ma[0], ms[0]);
        pb0 <= mem_read(ma[1], ms[1]);
        pb1 <= pb0;
        if (clr) begin
            for (int i = 0; i < 256; i++) bmem[i] <= 8'h00;
        end else begin
            for (int d = 0; d < 2; d++)
                if (mw[d])
                    for (int k = 0; k < 4; k++)
                        if (k < nbytes(ms[d])) bmem[8'(ma[d] + 32'(k))] <= md[d][8*k +: 8];
        end
    end
    assign mo[0] = pa;
    assign mo[1] = pb1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    typedef struct {
        int          d;
        int          c;
        logic [31:0] a;
        logic [1:0]  s;
        logic        w;
        logic [31:0] dat;
    } acc_t;

    acc_t        sched [$];
    int          busy_end [2] = '{-1, -1};
    int          rsp_at   [2] = '{-1, -1};
    logic [31:0] exp_rd   [2];
    logic        exp_er   [2];
    logic [31:0] last_rd  [2];
    logic        last_er  [2];
    bit          checking = 1'b0;

    // Request-level model: derives access schedule and response from the rules
    task automatic model(input int d, input int n, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        bit legal, mis;
        int nb, step;
        logic [31:0] v, wm;
        acc_t e;
        legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        nb    = nbytes(f3[1:0]);
        mis   = (nb == 2 && a[0]) || (nb == 4 && a[1:0] != 2'b00);
        exp_rd[d] = 32'd0;
        exp_er[d] = 1'b0;
        if (!legal || (mis && !SPLIT[d])) begin
            exp_er[d] = 1'b1;
            rsp_at[d] = n + 1;
        end else begin
            if (!mis) begin
                wm = 32'd0;
                for (int k = 0; k < nb; k++) wm[8*k +: 8] = wd[8*k +: 8];
                e = '{d, n + 1, a, f3[1:0], we, wm};
                sched.push_back(e);
                rsp_at[d] = we ? n + 2 : n + 2 + LAT[d];
            end else begin
                step = we ? 1 : 1 + LAT[d];
                for (int k = 0; k < nb; k++) begin
                    e = '{d, n + 1 + k * step, a + 32'(k), 2'd0, we, {24'd0, wd[8*k +: 8]}};
                    sched.push_back(e);
                end
                rsp_at[d] = n + 1 + nb * step;
            end
            if (we) begin
                for (int k = 0; k < nb; k++) rmem[8'(a + 32'(k))] = wd[8*k +: 8];
            end else begin
                v = 32'd0;
                for (int k = 0; k < nb; k++) v[8*k +: 8] = rmem[8'(a + 32'(k))];
                case (f3)
                    3'd0:    exp_rd[d] = {{24{v[7]}}, v[7:0]};
                    3'd1:    exp_rd[d] = {{16{v[15]}}, v[15:0]};
                    default: exp_rd[d] = v;
                endcase
            end
        end
        busy_end[d] = rsp_at[d];
    endtask

    // Per-cycle compare against the model
    initial begin
        bit hit;
        forever begin
            @(negedge clk);
            if (rst_n && checking) begin
                for (int d = 0; d < 2; d++) begin
                    chk($sformatf("dut%0d req_ready", d), {31'd0, rdy[d]}, {31'd0, cyc > busy_end[d]});
                    if (cyc == rsp_at[d]) begin
                        chk($sformatf("dut%0d rsp_valid", d), {31'd0, rv[d]}, 32'd1);
                        chk($sformatf("dut%0d rsp_rdata", d), rd[d], exp_rd[d]);
                        chk($sformatf("dut%0d rsp_err", d), {31'd0, re[d]}, {31'd0, exp_er[d]});
                        last_rd[d] = rd[d];
                        last_er[d] = re[d];
                    end else begin
                        chk($sformatf("dut%0d idle rsp", d), {rd[d][29:0], rv[d], re[d]}, 32'd0);
                    end
                    hit = 1'b0;
                    foreach (sched[i]) begin
                        if (sched[i].d == d && sched[i].c == cyc) begin
                            hit = 1'b1;
                            chk($sformatf("dut%0d mem_addr", d), ma[d], sched[i].a);
                            chk($sformatf("dut%0d mem_sel", d), {30'd0, ms[d]}, {30'd0, sched[i].s});
                            chk($sformatf("dut%0d mem_wen", d), {31'd0, mw[d]}, {31'd0, sched[i].w});
                            if (sched[i].w) chk($sformatf("dut%0d mem_data_i", d), md[d], sched[i].dat);
                        end
                    end
                    if (!hit) chk($sformatf("dut%0d mem_wen idle", d), {31'd0, mw[d]}, 32'd0);
                end
            end
        end
    end

    task automatic issue(input int d, input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input bit keep, output int n);
        int tmo;
        tmo = 0;
        req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        vld[d] = 1'b1;
        while (!rdy[d]) begin
            tmo++;
            if (tmo > 60) begin
                checks++; errors++;
                $display("FAIL dut%0d accept timeout", d);
                vld[d] = 1'b0;
                n = cyc;
                return;
            end
            @(negedge clk); #1;
        end
        n = cyc;
        model(d, n, we, f3, a, wd);
        @(negedge clk); #1;
        if (!keep) vld[d] = 1'b0;
        req_addr = ~a;   // later input changes must not matter
    endtask

    task automatic wait_done(input int d);
        int tmo;
        tmo = 0;
        while (cyc <= busy_end[d]) begin
            tmo++;
            if (tmo > 60) begin
                checks++; errors++;
                $display("FAIL dut%0d response timeout", d);
                return;
            end
            @(negedge clk); #1;
        end
    endtask

    task automatic op(input int d, input logic we, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, output int n);
        issue(d, we, f3, a, wd, 1'b0, n);
        wait_done(d);
    endtask

    task automatic chk_reset_vals(input int d);
        chk($sformatf("dut%0d rst req_ready", d), {31'd0, rdy[d]}, 32'd1);
        chk($sformatf("dut%0d rst rsp", d), {29'd0, rv[d], re[d], mw[d]}, 32'd0);
        chk($sformatf("dut%0d rst rsp_rdata", d), rd[d], 32'd0);
        chk($sformatf("dut%0d rst mem_addr", d), ma[d], 32'd0);
        chk($sformatf("dut%0d rst mem_sel", d), {30'd0, ms[d]}, 32'd0);
        chk($sformatf("dut%0d rst mem_data_i", d), md[d], 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, n2;
        rst_n = 1'b0; clr = 1'b1;
        vld[0] = 1'b0; vld[1] = 1'b0;
        req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
        for (int i = 0; i < 256; i++) rmem[i] = 8'h00;
        repeat (3) @(negedge clk);
        #1;
        chk_reset_vals(0);
        chk_reset_vals(1);
        rst_n = 1'b1; clr = 1'b0; checking = 1'b1;
        @(negedge clk); #1;

        // SW aligned: response two cycles after accept
        op(0, 1'b1, 3'b010, 32'h4, 32'h000000F5, n);
        chk("t1 latency", 32'(rsp_at[0] - n), 32'd2);
        chk("t1 err", {31'd0, last_er[0]}, 32'd0);

        // LB / LBU of 0x80
        op(0, 1'b1, 3'b000, 32'h8, 32'h00000080, n);
        op(0, 1'b0, 3'b000, 32'h8, 32'h0, n);
        chk("t2 LB latency", 32'(rsp_at[0] - n), 32'd3);
        chk("t2 LB data", last_rd[0], 32'hFFFFFF80);
        op(0, 1'b0, 3'b100, 32'h8, 32'h0, n);
        chk("t2 LBU data", last_rd[0], 32'h00000080);

        // Split store and split loads
        op(0, 1'b1, 3'b010, 32'h1, 32'hAABBCCDD, n);
        chk("t3 SW split latency", 32'(rsp_at[0] - n), 32'd5);
        op(0, 1'b0, 3'b010, 32'h1, 32'h0, n);
        chk("t3 LW split latency", 32'(rsp_at[0] - n), 32'd9);
        chk("t3 LW split data", last_rd[0], 32'hAABBCCDD);
        op(0, 1'b0, 3'b001, 32'h3, 32'h0, n);
        chk("t3 LH split data", last_rd[0], 32'hFFFFAABB);
        op(0, 1'b0, 3'b101, 32'h2, 32'h0, n);
        chk("t3 LHU data", last_rd[0], 32'h0000BBCC);

        // Illegal funct3
        op(0, 1'b0, 3'b011, 32'h0, 32'h0, n);
        chk("t4 illegal load err", {31'd0, last_er[0]}, 32'd1);
        op(0, 1'b1, 3'b100, 32'h0, 32'hFFFFFFFF, n);
        chk("t4 illegal store err", {31'd0, last_er[0]}, 32'd1);

        // Back-to-back with req_valid held high
        issue(0, 1'b1, 3'b010, 32'h10, 32'h12345678, 1'b1, n);
        issue(0, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, n2);
        chk("t5 second accept", 32'(n2 - n), 32'd3);
        wait_done(0);
        chk("t5 readback", last_rd[0], 32'h12345678);

        // Split word across the top of the address space
        op(0, 1'b1, 3'b010, 32'hFFFFFFFE, 32'h55667788, n);
        op(0, 1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, n);
        chk("wrap LW data", last_rd[0], 32'h55667788);
        op(0, 1'b0, 3'b101, 32'h0, 32'h0, n);
        chk("wrap LHU data", last_rd[0], 32'h00005566);

        // Reset during a split store after its first byte
        issue(0, 1'b1, 3'b010, 32'h21, 32'h11223344, 1'b0, n);
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk_reset_vals(0);
        sched.delete();
        rsp_at[0] = -1;
        busy_end[0] = cyc;
        for (int k = 2; k < 5; k++) rmem[8'(32'h20 + 32'(k))] = 8'h00;
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk); #1;
        op(0, 1'b0, 3'b010, 32'h21, 32'h0, n);
        chk("t6 partial store", last_rd[0], 32'h00000044);

        // Unsplit, latency-2 instance
        op(1, 1'b0, 3'b001, 32'h3, 32'h0, n);
        chk("b LH misaligned latency", 32'(rsp_at[1] - n), 32'd1);
        chk("b LH misaligned err", {31'd0, last_er[1]}, 32'd1);
        chk("b LH misaligned rdata", last_rd[1], 32'd0);
        op(1, 1'b0, 3'b011, 32'h4, 32'h0, n);
        chk("b illegal err", {31'd0, last_er[1]}, 32'd1);
        op(1, 1'b1, 3'b010, 32'h5, 32'hCAFEF00D, n);
        chk("b SW misaligned err", {31'd0, last_er[1]}, 32'd1);
        op(1, 1'b0, 3'b010, 32'h10, 32'h0, n);
        chk("b LW latency", 32'(rsp_at[1] - n), 32'd4);
        chk("b LW data", last_rd[1], 32'h12345678);
        op(1, 1'b0, 3'b001, 32'h12, 32'h0, n);
        chk("b LH data", last_rd[1], 32'h00001234);
        op(1, 1'b1, 3'b000, 32'h30, 32'h000000FE, n);
        op(1, 1'b0, 3'b000, 32'h30, 32'h0, n);
        chk("b LB data", last_rd[1], 32'hFFFFFFFE);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
